bias_group_sequencer: RTL and testbench

- Sequences the per-filter-group bias constants into the layer output path.
- Consumes 16-lane 18-bit adder-tree results, tracks which filter group and output pixel is active, selects that group's bias vector, adds it with saturation and emits the biased lanes downstream.
- Sits between the adder tree and the activation/requantisation stage of one layer.
- The concatenated outputs of the layer's BIAS_layer* constant banks drive its bias bus.

---
 rtl/bias_group_sequencer_pkg.sv | 16 +
 rtl/bias_sat_add.sv | 22 ++
 rtl/bias_group_sequencer.sv | 102 ++++++++++
 tb/tb_bias_group_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_group_sequencer_pkg.sv
// Shared types and constants for the layer bias stage.
// Lane width, saturation bounds and sequencer states.
package bias_group_sequencer_pkg;

  localparam int DW = 18;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/bias_sat_add.sv
// Single-lane signed add with saturation to DW bits.
// Purely combinational; shared by every layer's bias stage.
module bias_sat_add
  import bias_group_sequencer_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum
);

  logic [DW:0] wide;

  // One guard bit; a disagreeing top pair means overflow.
  always_comb begin
    wide = {a[DW-1], a} + {b[DW-1], b};
    sum  = wide[DW-1:0];
    if (wide[DW] != wide[DW-1]) begin
      sum = wide[DW] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/bias_group_sequencer.sv
// Adds the active filter group's bias to adder-tree lanes.
// Tracks group/pixel position and drains the last beat.
module bias_group_sequencer
  import bias_group_sequencer_pkg::*;
#(
  parameter  int N_adder_tree = 16,
  parameter  int N_GROUPS     = 4,
  parameter  int PIXELS       = 64,
  localparam int LW = N_adder_tree * DW,
  localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_GROUPS*LW-1:0] bias_bus,
  input  logic [LW-1:0]          in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [GW-1:0]          group_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PIXELS - 1);
  localparam logic [GW-1:0] G_LAST = GW'(N_GROUPS - 1);

  state_t        state;
  logic [PW-1:0] pixel;
  logic [LW-1:0] bias_sel;
  logic [LW-1:0] sum;
  logic          accept;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign bias_sel = bias_bus[int'(group_idx)*LW +: LW];

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_sat_add u_add (
      .a   (in_data[i*DW +: DW]),
      .b   (bias_sel[i*DW +: DW]),
      .sum (sum[i*DW +: DW])
    );
  end

  // Sequencer: group/pixel counters plus the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      group_idx <= '0;
      pixel     <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_data  <= sum;
        out_valid <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            group_idx <= '0;
            pixel     <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (pixel == P_LAST) begin
              pixel <= '0;
              if (group_idx == G_LAST) begin
                state <= DRAIN;
              end else begin
                group_idx <= group_idx + 1'b1;
              end
            end else begin
              pixel <= pixel + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            done      <= 1'b1;
            state     <= IDLE;
            group_idx <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_group_sequencer.sv
// Scoreboard bench for the bias group sequencer.
// Small config: 2 groups of 3 pixels, 16 lanes.
module tb_bias_group_sequencer;
  import bias_group_sequencer_pkg::*;

  localparam int NL = 16;
  localparam int NG = 2;
  localparam int PX = 3;
  localparam int LW = NL * DW;
  localparam int GW = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NG*LW-1:0] bias_bus;
  logic [LW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [LW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic [GW-1:0]    group_idx;
  logic             busy;
  logic             done;

  logic [DW-1:0] bias_m [NG][NL];
  logic [LW-1:0] sb [$];
  logic [LW-1:0] d;
  logic [LW-1:0] held;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int mpix = 0;
  int mgrp = 0;

  always #5 clk = ~clk;

  bias_group_sequencer #(
    .N_adder_tree (NL),
    .N_GROUPS     (NG),
    .PIXELS       (PX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias_bus  (bias_bus),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .group_idx (group_idx),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(string tag, logic [LW-1:0] got,
                     logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] model(logic [LW-1:0] x, int g);
    logic [LW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      s = int'($signed(x[i*DW +: DW])) + int'($signed(bias_m[g][i]));
      if (s > 131071) s = 131071;
      else if (s < -131072) s = -131072;
      r[i*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [LW-1:0] rnd();
    logic [LW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Handshakes are judged mid-cycle, inputs change just after posedge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mpix = 0;
      mgrp = 0;
    end else begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_extra", LW'(sb.size()), LW'(1));
        else chk("sb_data", out_data, sb.pop_front());
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data, mgrp));
        if (mpix == PX - 1) begin
          mpix = 0;
          mgrp = (mgrp + 1) % NG;
        end else begin
          mpix++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_beat(logic [LW-1:0] x);
    bit acc;
    acc = 1'b0;
    in_data  = x;
    in_valid = 1'b1;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_to", LW'(acc), LW'(1));
  endtask

  task automatic wait_done(int n_exp);
    for (int n = 0; n < 20 && done_cnt < n_exp; n++) step();
    chk("done_cnt", LW'(done_cnt), LW'(n_exp));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int g = 0; g < NG; g++)
      for (int i = 0; i < NL; i++) bias_m[g][i] = DW'($urandom);
    bias_m[0][0] = 18'h0139C;
    bias_m[0][1] = 18'h3FFB4;
    for (int g = 0; g < NG; g++)
      for (int i = 0; i < NL; i++)
        bias_bus[g*LW + i*DW +: DW] = bias_m[g][i];

    repeat (2) step();
    chk("rst_valid", LW'(out_valid), LW'(0));
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_grp", LW'(group_idx), LW'(0));
    chk("rst_done", LW'(done), LW'(0));
    chk("rst_data", out_data, '0);
    chk("rst_ready", LW'(in_ready), LW'(0));
    rst = 1'b0;
    step();

    in_valid = 1'b1;
    in_data  = rnd();
    repeat (3) begin
      step();
      chk("idle_ready", LW'(in_ready), LW'(0));
      chk("idle_valid", LW'(out_valid), LW'(0));
    end
    in_valid = 1'b0;

    pulse_start();
    chk("run_busy", LW'(busy), LW'(1));
    d = rnd();
    d[0 +: DW]  = 18'd100;
    d[DW +: DW] = 18'd50;
    send_beat(d);
    chk("lat_valid", LW'(out_valid), LW'(1));
    chk("add_l0", LW'(out_data[0 +: DW]), LW'(18'd5120));
    chk("add_l1", LW'(out_data[DW +: DW]), LW'(18'h3FFE6));

    d = rnd();
    d[0 +: DW]  = 18'h1FF00;
    d[DW +: DW] = 18'h20010;
    send_beat(d);
    chk("sat_hi", LW'(out_data[0 +: DW]), LW'(18'h1FFFF));
    chk("sat_lo", LW'(out_data[DW +: DW]), LW'(18'h20000));
    chk("grp_p1", LW'(group_idx), LW'(0));
    send_beat(rnd());
    chk("grp_adv", LW'(group_idx), LW'(1));

    out_ready = 1'b0;
    in_data   = rnd();
    in_valid  = 1'b1;
    held      = out_data;
    repeat (4) begin
      step();
      chk("bp_ready", LW'(in_ready), LW'(0));
      chk("bp_hold", out_data, held);
      chk("bp_valid", LW'(out_valid), LW'(1));
    end
    out_ready = 1'b1;
    send_beat(in_data);
    send_beat(rnd());
    send_beat(rnd());
    wait_done(1);
    chk("end_busy", LW'(busy), LW'(0));
    chk("end_grp", LW'(group_idx), LW'(0));

    pulse_start();
    send_beat(rnd());
    send_beat(rnd());
    pulse_start();
    chk("st_ign_grp", LW'(group_idx), LW'(0));
    send_beat(rnd());
    chk("st_ign_adv", LW'(group_idx), LW'(1));
    chk("st_ign_busy", LW'(busy), LW'(1));
    repeat (3) send_beat(rnd());
    wait_done(2);

    pulse_start();
    send_beat(rnd());
    send_beat(rnd());
    out_ready = 1'b0;
    chk("pre_rst_val", LW'(out_valid), LW'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_val", LW'(out_valid), LW'(0));
    chk("mid_rst_busy", LW'(busy), LW'(0));
    chk("mid_rst_grp", LW'(group_idx), LW'(0));
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    pulse_start();
    repeat (6) send_beat(rnd());
    wait_done(3);
    chk("sb_left", LW'(sb.size()), LW'(0));
    chk("fin_busy", LW'(busy), LW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
